// File: rtl/exe_muldiv_unit_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit.
// Holds the MDOp encodings, default per-operation latencies and the FSM state type.
package exe_muldiv_unit_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    localparam int unsigned DEF_MUL_CYCLES = 5;
    localparam int unsigned DEF_DIV_CYCLES = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    // Larger of two latencies; sizes the shared busy counter.
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/exe_muldiv_unit_md_calc.sv
// Combinational HI/LO result generator for MULT/MULTU/DIV/DIVU.
// Ports:
//   MDOp  in  3      operation select (non mul/div ops yield zero)
//   A     in  WIDTH  rs operand (multiplicand / dividend)
//   B     in  WIDTH  rt operand (multiplier / divisor)
//   hi    out WIDTH  upper product half or remainder
//   lo    out WIDTH  lower product half or quotient
module exe_muldiv_unit_md_calc
    import exe_muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [2:0]       MDOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned PW = 2 * WIDTH;

    logic                    div_zero;
    logic                    div_ovf;
    logic [PW-1:0]           prod_s;
    logic [PW-1:0]           prod_u;
    logic signed [WIDTH-1:0] sdvd;
    logic signed [WIDTH-1:0] sdvs;
    logic signed [WIDTH-1:0] q_s;
    logic signed [WIDTH-1:0] r_s;
    logic [WIDTH-1:0]        udvs;
    logic [WIDTH-1:0]        q_u;
    logic [WIDTH-1:0]        r_u;

    always_comb begin
        div_zero = (B == '0);
        div_ovf  = (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);

        // Low PW bits of a product of sign-extended operands equal the signed product.
        prod_s = {{WIDTH{A[WIDTH-1]}}, A} * {{WIDTH{B[WIDTH-1]}}, B};
        prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

        // Special-case divisors are replaced by 1 so the dividers never see them.
        sdvd = $signed(A);
        sdvs = $signed((div_zero || div_ovf) ? WIDTH'(1) : B);
        q_s  = sdvd / sdvs;
        r_s  = sdvd % sdvs;

        udvs = div_zero ? WIDTH'(1) : B;
        q_u  = A / udvs;
        r_u  = A % udvs;

        hi = '0;
        lo = '0;
        case (MDOp)
            MD_MULT:  {hi, lo} = prod_s;
            MD_MULTU: {hi, lo} = prod_u;
            MD_DIV: begin
                if (div_zero) begin
                    hi = A;
                    lo = '1;
                end else if (div_ovf) begin
                    hi = '0;
                    lo = A;
                end else begin
                    hi = r_s;
                    lo = q_s;
                end
            end
            MD_DIVU: begin
                if (div_zero) begin
                    hi = A;
                    lo = '1;
                end else begin
                    hi = r_u;
                    lo = q_u;
                end
            end
            default: begin
                hi = '0;
                lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/exe_muldiv_unit.sv
// Execute-stage multi-cycle multiply/divide unit with architectural HI/LO.
// Ports:
//   Clk     in  1      clock, rising edge
//   Reset   in  1      synchronous active-high reset
//   Start   in  1      E-stage instruction is an MD op this cycle
//   MDOp    in  3      MULT/MULTU/DIV/DIVU/MTHI/MTLO, 6-7 no-op
//   A, B    in  WIDTH  forwarded rs / rt operands
//   exp_in  in  1      exception flush of the E-stage instruction
//   Busy    out 1      operation in progress (registered)
//   HI, LO  out WIDTH  architectural HI/LO (registered)
module exe_muldiv_unit
    import exe_muldiv_unit_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int unsigned DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       MDOp,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             exp_in,
    output logic             Busy,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int unsigned CNT_W = $clog2(max_u(MUL_CYCLES, DIV_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    md_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [WIDTH-1:0] pend_hi, pend_hi_next;
    logic [WIDTH-1:0] pend_lo, pend_lo_next;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic             busy_next;
    logic [WIDTH-1:0] calc_hi, calc_lo;
    logic             accepted;

    exe_muldiv_unit_md_calc #(
        .WIDTH (WIDTH)
    ) u_md_calc (
        .MDOp (MDOp),
        .A    (A),
        .B    (B),
        .hi   (calc_hi),
        .lo   (calc_lo)
    );

    // A flushed instruction never reaches the unit; a busy unit ignores new work.
    assign accepted = Start & ~exp_in & ~Busy;

    // Next-state, counter, pending-result and HI/LO update logic.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        pend_hi_next = pend_hi;
        pend_lo_next = pend_lo;
        hi_next      = HI;
        lo_next      = LO;
        busy_next    = Busy;

        case (state)
            ST_IDLE: begin
                if (accepted) begin
                    case (MDOp)
                        MD_MTHI: hi_next = A;
                        MD_MTLO: lo_next = A;
                        MD_MULT, MD_MULTU: begin
                            pend_hi_next = calc_hi;
                            pend_lo_next = calc_lo;
                            cnt_next     = MUL_LOAD;
                            state_next   = ST_BUSY;
                            busy_next    = 1'b1;
                        end
                        MD_DIV, MD_DIVU: begin
                            pend_hi_next = calc_hi;
                            pend_lo_next = calc_lo;
                            cnt_next     = DIV_LOAD;
                            state_next   = ST_BUSY;
                            busy_next    = 1'b1;
                        end
                        default: begin
                            state_next = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_BUSY: begin
                if (cnt == '0) begin
                    hi_next    = pend_hi;
                    lo_next    = pend_lo;
                    state_next = ST_IDLE;
                    busy_next  = 1'b0;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_next = ST_IDLE;
                busy_next  = 1'b0;
            end
        endcase
    end

    // State and architectural registers; reset discards any operation in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
            HI      <= '0;
            LO      <= '0;
            Busy    <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pend_hi <= pend_hi_next;
            pend_lo <= pend_lo_next;
            HI      <= hi_next;
            LO      <= lo_next;
            Busy    <= busy_next;
        end
    end

endmodule

// File: tb/tb_exe_muldiv_unit.sv
// Self-checking bench for exe_muldiv_unit: directed cases plus randomized
// operations compared against an arithmetic reference model.
module tb_exe_muldiv_unit;
    import exe_muldiv_unit_pkg::*;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        exp_in;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          proto_cnt = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    always #5 Clk = ~Clk;

    exe_muldiv_unit #(
        .WIDTH      (32),
        .MUL_CYCLES (MUL_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Start  (Start),
        .MDOp   (MDOp),
        .A      (A),
        .B      (B),
        .exp_in (exp_in),
        .Busy   (Busy),
        .HI     (HI),
        .LO     (LO)
    );

    // Start while Busy is a hazard-unit protocol error; count occurrences.
    always @(negedge Clk) begin
        if (Start === 1'b1 && Busy === 1'b1 && Reset === 1'b0)
            proto_cnt <= proto_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference: {HI, LO} from the architectural arithmetic rules.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] res;
        int          sa, sb, q, r;
        res = '0;
        case (op)
            MD_MULT:  res = 64'(longint'($signed(a)) * longint'($signed(b)));
            MD_MULTU: res = {32'h0, a} * {32'h0, b};
            MD_DIV: begin
                if (b == 32'h0)
                    res = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
                    res = {32'h0, a};
                else begin
                    sa  = $signed(a);
                    sb  = $signed(b);
                    q   = sa / sb;
                    r   = sa - q * sb;
                    res = {32'(r), 32'(q)};
                end
            end
            MD_DIVU: begin
                if (b == 32'h0)
                    res = {a, 32'hFFFF_FFFF};
                else
                    res = {a % b, a / b};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    // Issue one mul/div op and check Busy window, HI/LO hold and final commit.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input string name);
        logic [63:0] r;
        int          n;
        r = model(op, a, b);
        n = (op == MD_MULT || op == MD_MULTU) ? MUL_N : DIV_N;
        Start = 1'b1; MDOp = op; A = a; B = b; exp_in = 1'b0;
        tick();
        Start = 1'b0;
        A = $urandom; B = $urandom; MDOp = 3'($urandom_range(0, 7));
        for (int k = 1; k <= n; k++) begin
            n_checks++;
            if (Busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy_cycle_%0d: Busy=%b required 1", name, k, Busy);
            end
            n_checks++;
            if (HI !== exp_hi || LO !== exp_lo) begin
                n_fail++;
                $display("FAIL %s hold_cycle_%0d: HI=%h LO=%h required HI=%h LO=%h",
                         name, k, HI, LO, exp_hi, exp_lo);
            end
            tick();
        end
        exp_hi = r[63:32];
        exp_lo = r[31:0];
        n_checks++;
        if (Busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_clear: Busy=%b required 0", name, Busy);
        end
        n_checks++;
        if (HI !== exp_hi || LO !== exp_lo) begin
            n_fail++;
            $display("FAIL %s result: HI=%h LO=%h required HI=%h LO=%h",
                     name, HI, LO, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset;
        Reset = 1'b1; Start = 1'b0; exp_in = 1'b0; MDOp = 3'd0; A = '0; B = '0;
        tick();
        tick();
        Reset = 1'b0;
        n_checks++;
        if (Busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: Busy=%b required 0", Busy);
        end
        n_checks++;
        if (HI !== 32'h0) begin
            n_fail++; $display("FAIL reset_hi: HI=%h required 0", HI);
        end
        n_checks++;
        if (LO !== 32'h0) begin
            n_fail++; $display("FAIL reset_lo: LO=%h required 0", LO);
        end
        exp_hi = '0; exp_lo = '0;
    endtask

    task automatic test_mult;
        run_op(MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002, "mult");
        n_checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFE) begin
            n_fail++; $display("FAIL mult_const: HI=%h LO=%h required HI=ffffffff LO=fffffffe", HI, LO);
        end
        run_op(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002, "multu");
        n_checks++;
        if (HI !== 32'h0000_0001 || LO !== 32'hFFFF_FFFE) begin
            n_fail++; $display("FAIL multu_const: HI=%h LO=%h required HI=00000001 LO=fffffffe", HI, LO);
        end
    endtask

    task automatic test_div;
        run_op(MD_DIV, 32'hFFFF_FFF9, 32'h0000_0002, "div");
        n_checks++;
        if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
            n_fail++; $display("FAIL div_const: HI=%h LO=%h required HI=ffffffff LO=fffffffd", HI, LO);
        end
        run_op(MD_DIVU, 32'h0000_0005, 32'h0000_0000, "divu_zero");
        n_checks++;
        if (HI !== 32'h0000_0005 || LO !== 32'hFFFF_FFFF) begin
            n_fail++; $display("FAIL divu_zero_const: HI=%h LO=%h required HI=00000005 LO=ffffffff", HI, LO);
        end
        run_op(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        n_checks++;
        if (HI !== 32'h0 || LO !== 32'h8000_0000) begin
            n_fail++; $display("FAIL div_ovf_const: HI=%h LO=%h required HI=00000000 LO=80000000", HI, LO);
        end
    endtask

    task automatic test_flush;
        Start = 1'b1; MDOp = MD_MULT; A = $urandom; B = $urandom; exp_in = 1'b1;
        tick();
        n_checks++;
        if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
            n_fail++; $display("FAIL flush_mult: Busy=%b HI=%h LO=%h required Busy=0 HI=%h LO=%h",
                               Busy, HI, LO, exp_hi, exp_lo);
        end
        MDOp = MD_MTLO; A = $urandom | 32'h1;
        tick();
        n_checks++;
        if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
            n_fail++; $display("FAIL flush_mtlo: Busy=%b HI=%h LO=%h required Busy=0 HI=%h LO=%h",
                               Busy, HI, LO, exp_hi, exp_lo);
        end
        MDOp = MD_MTHI; A = 32'h0000_1234; exp_in = 1'b0;
        tick();
        Start = 1'b0;
        exp_hi = 32'h0000_1234;
        n_checks++;
        if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
            n_fail++; $display("FAIL mthi: Busy=%b HI=%h LO=%h required Busy=0 HI=%h LO=%h",
                               Busy, HI, LO, exp_hi, exp_lo);
        end
        tick();
        n_checks++;
        if (Busy !== 1'b0 || HI !== exp_hi) begin
            n_fail++; $display("FAIL mthi_after: Busy=%b HI=%h required Busy=0 HI=%h", Busy, HI, exp_hi);
        end
    endtask

    task automatic test_busy_ignore;
        logic [31:0] a, b;
        logic [63:0] r;
        a = $urandom;
        b = $urandom_range(1, 32'h0000_FFFF);
        r = model(MD_DIVU, a, b);
        Start = 1'b1; MDOp = MD_DIVU; A = a; B = b; exp_in = 1'b0;
        tick();
        Start = 1'b0;
        for (int k = 1; k <= DIV_N; k++) begin
            if (k == 3) begin
                Start = 1'b1; MDOp = MD_MULT; A = $urandom; B = $urandom;
            end
            n_checks++;
            if (Busy !== 1'b1) begin
                n_fail++; $display("FAIL busy_ignore_cycle_%0d: Busy=%b required 1", k, Busy);
            end
            tick();
            Start = 1'b0;
        end
        exp_hi = r[63:32]; exp_lo = r[31:0];
        n_checks++;
        if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
            n_fail++; $display("FAIL busy_ignore_commit: Busy=%b HI=%h LO=%h required Busy=0 HI=%h LO=%h",
                               Busy, HI, LO, exp_hi, exp_lo);
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
                n_fail++; $display("FAIL busy_ignore_after_%0d: Busy=%b HI=%h LO=%h required Busy=0 HI=%h LO=%h",
                                   k, Busy, HI, LO, exp_hi, exp_lo);
            end
        end
    endtask

    task automatic test_reset_mid;
        Start = 1'b1; MDOp = MD_DIVU; A = $urandom | 32'h100; B = 32'h3; exp_in = 1'b0;
        tick();
        Start = 1'b0;
        tick();
        tick();
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        exp_hi = '0; exp_lo = '0;
        n_checks++;
        if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
            n_fail++; $display("FAIL reset_mid: Busy=%b HI=%h LO=%h required all 0", Busy, HI, LO);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            n_checks++;
            if (Busy !== 1'b0 || HI !== 32'h0 || LO !== 32'h0) begin
                n_fail++; $display("FAIL reset_mid_after_%0d: Busy=%b HI=%h LO=%h required all 0",
                                   k, Busy, HI, LO);
            end
        end
    endtask

    task automatic test_random;
        logic [2:0]  op;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 7) == 0) begin
                a = 32'h8000_0000; b = 32'hFFFF_FFFF;
            end
            if (op <= MD_DIVU) begin
                run_op(op, a, b, "random");
            end else begin
                Start = 1'b1; MDOp = op; A = a; B = b; exp_in = 1'b0;
                tick();
                Start = 1'b0;
                if (op == MD_MTHI) exp_hi = a;
                if (op == MD_MTLO) exp_lo = a;
                n_checks++;
                if (Busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
                    n_fail++; $display("FAIL random_op%0d: Busy=%b HI=%h LO=%h required Busy=0 HI=%h LO=%h",
                                       op, Busy, HI, LO, exp_hi, exp_lo);
                end
            end
        end
    endtask

    task automatic test_protocol;
        n_checks++;
        if (proto_cnt !== 1) begin
            n_fail++; $display("FAIL protocol_count: start_while_busy=%0d required 1", proto_cnt);
        end
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; exp_in = 1'b0; MDOp = 3'd0; A = '0; B = '0;
        test_reset();
        test_mult();
        test_div();
        test_flush();
        test_busy_ignore();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
